param_datapath: RTL and testbench

PARAM_DATAPATH -- requirements
Module: param_datapath

---
 rtl/datapath_pkg.sv | 39 +++
 rtl/dp_alu.sv | 59 +++++
 rtl/param_datapath.sv | 173 +++++++++++++++++
 tb/tb_param_datapath.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared encodings for the parameterised datapath: command fields, FSM states
// and status-bit positions.
package datapath_pkg;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_AND  = 2'b10,
    ALU_NOTB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    WB_ALU   = 2'b00,
    WB_IMM   = 2'b01,
    WB_PC    = 2'b10,
    WB_MDATA = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_e;

  // status = {Z, N, V}
  localparam int ST_Z = 2;
  localparam int ST_N = 1;
  localparam int ST_V = 0;

endpackage

// File: rtl/dp_alu.sv
// Combinational operand shaping (A zeroing, B shift / immediate select),
// ALU and {Z,N,V} flag generation.
module dp_alu
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  input  logic             a_zero,
  input  logic             b_imm,
  input  logic [1:0]       shift,
  input  logic [1:0]       alu_op,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] b_eff;
  logic             v;

  always_comb begin
    a_eff = a_zero ? '0 : a;

    b_sh = b;
    case (shift)
      SH_LSL1: b_sh = {b[MSB-1:0], 1'b0};
      SH_LSR1: b_sh = {1'b0, b[MSB:1]};
      SH_ASR1: b_sh = {b[MSB], b[MSB:1]};
      default: b_sh = b;
    endcase
    b_eff = b_imm ? imm : b_sh;

    result = '0;
    v      = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        result = a_eff + b_eff;
        v      = (a_eff[MSB] == b_eff[MSB]) && (result[MSB] != a_eff[MSB]);
      end
      ALU_SUB: begin
        result = a_eff - b_eff;
        v      = (a_eff[MSB] != b_eff[MSB]) && (result[MSB] != a_eff[MSB]);
      end
      ALU_AND: result = a_eff & b_eff;
      default: result = ~b_eff;
    endcase

    flags       = '0;
    flags[ST_Z] = (result == '0);
    flags[ST_N] = result[MSB];
    flags[ST_V] = v;
  end

endmodule

// File: rtl/param_datapath.sv
// Multi-cycle register-file datapath: latches a command on start, reads A/B,
// executes in dp_alu and writes back one selected source to the register file.
module param_datapath
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PCW   = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [$clog2(NREGS)-1:0] rd,
  input  logic [$clog2(NREGS)-1:0] rn,
  input  logic [$clog2(NREGS)-1:0] rm,
  input  logic [1:0]               alu_op,
  input  logic [1:0]               shift,
  input  logic                     a_zero,
  input  logic                     b_imm,
  input  logic                     wr_en,
  input  logic                     ld_status,
  input  logic [1:0]               wb_sel,
  input  logic [WIDTH-1:0]         imm,
  input  logic [WIDTH-1:0]         mdata,
  input  logic [PCW-1:0]           pc,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               status,
  output logic [WIDTH-1:0]         datapath_out
);

  localparam int RW = $clog2(NREGS);

  state_e state_reg, state_next;

  logic [RW-1:0]    cmd_rd_reg, cmd_rn_reg, cmd_rm_reg;
  logic [1:0]       cmd_alu_op_reg, cmd_shift_reg, cmd_wb_sel_reg;
  logic             cmd_a_zero_reg, cmd_b_imm_reg, cmd_wr_en_reg, cmd_ld_status_reg;
  logic [WIDTH-1:0] cmd_imm_reg, cmd_mdata_reg;
  logic [PCW-1:0]   cmd_pc_reg;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] a_reg, b_reg, c_reg;
  logic [2:0]       status_reg;

  logic [WIDTH-1:0] alu_result;
  logic [2:0]       alu_flags;
  logic [WIDTH-1:0] wb_data;
  logic             wb_write;
  logic [NREGS-1:0] reg_we;
  logic             accept;

  assign accept = (state_reg == S_IDLE) && start;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        // Non-ALU sources need no operand reads, so they go straight to write-back.
        if (start) state_next = (wb_sel == WB_ALU) ? S_RD_A : S_WB;
      end
      S_RD_A: state_next = S_RD_B;
      S_RD_B: state_next = S_EXEC;
      S_EXEC: state_next = S_WB;
      S_WB: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_rd_reg        <= '0;
      cmd_rn_reg        <= '0;
      cmd_rm_reg        <= '0;
      cmd_alu_op_reg    <= '0;
      cmd_shift_reg     <= '0;
      cmd_wb_sel_reg    <= '0;
      cmd_a_zero_reg    <= 1'b0;
      cmd_b_imm_reg     <= 1'b0;
      cmd_wr_en_reg     <= 1'b0;
      cmd_ld_status_reg <= 1'b0;
      cmd_imm_reg       <= '0;
      cmd_mdata_reg     <= '0;
      cmd_pc_reg        <= '0;
    end else if (accept) begin
      cmd_rd_reg        <= rd;
      cmd_rn_reg        <= rn;
      cmd_rm_reg        <= rm;
      cmd_alu_op_reg    <= alu_op;
      cmd_shift_reg     <= shift;
      cmd_wb_sel_reg    <= wb_sel;
      cmd_a_zero_reg    <= a_zero;
      cmd_b_imm_reg     <= b_imm;
      cmd_wr_en_reg     <= wr_en;
      cmd_ld_status_reg <= ld_status;
      cmd_imm_reg       <= imm;
      cmd_mdata_reg     <= mdata;
      cmd_pc_reg        <= pc;
    end
  end

  dp_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (a_reg),
    .b      (b_reg),
    .imm    (cmd_imm_reg),
    .a_zero (cmd_a_zero_reg),
    .b_imm  (cmd_b_imm_reg),
    .shift  (cmd_shift_reg),
    .alu_op (cmd_alu_op_reg),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_reg      <= '0;
      b_reg      <= '0;
      c_reg      <= '0;
      status_reg <= '0;
    end else begin
      if (state_reg == S_RD_A) a_reg <= regs[cmd_rn_reg];
      if (state_reg == S_RD_B) b_reg <= regs[cmd_rm_reg];
      if (state_reg == S_EXEC) begin
        c_reg <= alu_result;
        if (cmd_ld_status_reg) status_reg <= alu_flags;
      end
    end
  end

  always_comb begin
    wb_data = c_reg;
    case (cmd_wb_sel_reg)
      WB_IMM:   wb_data = cmd_imm_reg;
      WB_PC:    wb_data = WIDTH'(cmd_pc_reg);
      WB_MDATA: wb_data = cmd_mdata_reg;
      default:  wb_data = c_reg;
    endcase
  end

  assign wb_write = (state_reg == S_WB) && cmd_wr_en_reg;

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_we
      assign reg_we[gi] = wb_write && (cmd_rd_reg == RW'(gi));
    end
  endgenerate

  // Register file stays in flops: every entry must clear on the asynchronous reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (reg_we[i]) regs[i] <= wb_data;
      end
    end
  end

  assign status       = status_reg;
  assign datapath_out = c_reg;

endmodule

// File: tb/tb_param_datapath.sv
// Randomised self-checking bench for param_datapath against an arithmetic
// reference model of the register file, C register and status flags.
module tb_param_datapath #(
  parameter int W = 16,
  parameter int N = 8,
  parameter int P = 8
);

  localparam int RW = $clog2(N);
  localparam longint FULL = longint'(1) << W;
  localparam longint HALF = longint'(1) << (W - 1);
  localparam longint MASK = FULL - 1;

  typedef struct {
    logic [RW-1:0] rd, rn, rm;
    logic [1:0]    alu_op, shift, wb_sel;
    logic          a_zero, b_imm, wr_en, ld_status;
    logic [W-1:0]  imm, mdata;
    logic [P-1:0]  pc;
  } cmd_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] rd = '0, rn = '0, rm = '0;
  logic [1:0]    alu_op = '0, shift = '0, wb_sel = '0;
  logic          a_zero = 1'b0, b_imm = 1'b0, wr_en = 1'b0, ld_status = 1'b0;
  logic [W-1:0]  imm = '0, mdata = '0;
  logic [P-1:0]  pc = '0;
  logic          busy, done;
  logic [2:0]    status;
  logic [W-1:0]  datapath_out;

  int total = 0;
  int bad = 0;

  longint     m_regs [N];
  longint     m_c;
  logic [2:0] m_status;

  always #5 clk = ~clk;

  param_datapath #(.WIDTH(W), .NREGS(N), .PCW(P)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .rd(rd), .rn(rn), .rm(rm),
    .alu_op(alu_op), .shift(shift),
    .a_zero(a_zero), .b_imm(b_imm), .wr_en(wr_en), .ld_status(ld_status),
    .wb_sel(wb_sel), .imm(imm), .mdata(mdata), .pc(pc),
    .busy(busy), .done(done), .status(status), .datapath_out(datapath_out)
  );

  function automatic longint to_signed(input longint x);
    return (x >= HALF) ? x - FULL : x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_regs[i] = 0;
    m_c = 0;
    m_status = '0;
  endtask

  // Reference semantics computed with integer arithmetic on unsigned values.
  task automatic model_run(input cmd_t c);
    longint a, b, src, r, s, wv;
    bit v;
    wv = 0;
    if (c.wb_sel == 2'b00) begin
      a   = c.a_zero ? 0 : m_regs[c.rn];
      src = m_regs[c.rm];
      if (c.b_imm) b = longint'(c.imm);
      else begin
        case (c.shift)
          2'd0:    b = src;
          2'd1:    b = (src * 2) & MASK;
          2'd2:    b = src / 2;
          default: b = src / 2 + ((src >= HALF) ? HALF : 0);
        endcase
      end
      v = 1'b0;
      case (c.alu_op)
        2'd0: begin
          r = (a + b) & MASK;
          s = to_signed(a) + to_signed(b);
          v = (s >= HALF) || (s < -HALF);
        end
        2'd1: begin
          r = (a - b + FULL) & MASK;
          s = to_signed(a) - to_signed(b);
          v = (s >= HALF) || (s < -HALF);
        end
        2'd2:    r = a & b;
        default: r = MASK - b;
      endcase
      m_c = r;
      if (c.ld_status) m_status = {r == 0, r >= HALF, v};
      wv = r;
    end else if (c.wb_sel == 2'b01) wv = longint'(c.imm);
    else if (c.wb_sel == 2'b10) wv = longint'(c.pc);
    else wv = longint'(c.mdata);
    if (c.wr_en) m_regs[c.rd] = wv;
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.rd        = RW'($urandom_range(0, N - 1));
    c.rn        = RW'($urandom_range(0, N - 1));
    c.rm        = RW'($urandom_range(0, N - 1));
    c.alu_op    = 2'($urandom);
    c.shift     = 2'($urandom);
    c.wb_sel    = 2'($urandom);
    c.a_zero    = ($urandom_range(0, 3) == 0);
    c.b_imm     = ($urandom_range(0, 3) == 0);
    c.wr_en     = ($urandom_range(0, 3) != 0);
    c.ld_status = 1'($urandom);
    c.imm       = W'($urandom);
    c.mdata     = W'($urandom);
    c.pc        = P'($urandom);
    return c;
  endfunction

  task automatic drive(input cmd_t c);
    rd = c.rd; rn = c.rn; rm = c.rm;
    alu_op = c.alu_op; shift = c.shift; wb_sel = c.wb_sel;
    a_zero = c.a_zero; b_imm = c.b_imm; wr_en = c.wr_en; ld_status = c.ld_status;
    imm = c.imm; mdata = c.mdata; pc = c.pc;
  endtask

  // Issues one command, scrambles the inputs afterwards, measures start-to-done
  // latency and reports whether busy held and done lasted exactly one cycle.
  task automatic issue_cmd(input cmd_t c, output int lat, output bit clean);
    int drops;
    drive(c);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drive(rand_cmd());
    lat = 1;
    drops = 0;
    while (!done && lat < 20) begin
      if (!busy) drops++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
    else if (!busy) drops++;
    @(posedge clk); #1;
    clean = (drops == 0) && !done && !busy;
    model_run(c);
    $display("cmd wb=%0d op=%0d sh=%0d rd=%0d rn=%0d rm=%0d lat=%0d out=%h st=%b",
             c.wb_sel, c.alu_op, c.shift, c.rd, c.rn, c.rm, lat, datapath_out, status);
  endtask

  function automatic cmd_t read_cmd(input int n);
    cmd_t c;
    c = '{default: '0};
    c.rn = RW'(n);
    c.b_imm = 1'b1;
    return c;
  endfunction

  function automatic cmd_t imm_cmd(input int n, input longint val);
    cmd_t c;
    c = '{default: '0};
    c.rd = RW'(n);
    c.wb_sel = 2'b01;
    c.wr_en = 1'b1;
    c.imm = W'(val);
    return c;
  endfunction

  task automatic test_reset();
    int lat; bit clean;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (status !== 3'b000) begin bad++; $display("FAIL reset_status got=%b want=000", status); end
    total++; if (datapath_out !== '0) begin bad++; $display("FAIL reset_out got=%h want=0", datapath_out); end
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < N; i++) begin
      issue_cmd(read_cmd(i), lat, clean);
      total++;
      if (longint'(datapath_out) !== m_regs[i] || lat != 4) begin
        bad++; $display("FAIL reset_reg%0d got=%h lat=%0d want=%h lat=4", i, datapath_out, lat, m_regs[i]);
      end
    end
  endtask

  task automatic test_imm_write();
    int lat; bit clean;
    issue_cmd(imm_cmd(0, 7), lat, clean);
    total++; if (lat != 1 || !clean) begin bad++; $display("FAIL imm_latency got=%0d clean=%b want=1 clean=1", lat, clean); end
    total++; if (datapath_out !== '0) begin bad++; $display("FAIL imm_out_kept got=%h want=0", datapath_out); end
    issue_cmd(read_cmd(0), lat, clean);
    total++; if (longint'(datapath_out) !== 7) begin bad++; $display("FAIL imm_r0 got=%h want=7", datapath_out); end
  endtask

  task automatic test_add_shift();
    int lat; bit clean;
    cmd_t c;
    issue_cmd(imm_cmd(1, 3), lat, clean);
    c = '{default: '0};
    c.rd = RW'(2); c.rn = RW'(0); c.rm = RW'(1);
    c.shift = 2'b01; c.ld_status = 1'b1; c.wr_en = 1'b1;
    issue_cmd(c, lat, clean);
    total++; if (lat != 4 || !clean) begin bad++; $display("FAIL add_latency got=%0d clean=%b want=4 clean=1", lat, clean); end
    total++; if (longint'(datapath_out) !== 13) begin bad++; $display("FAIL add_out got=%h want=d", datapath_out); end
    total++; if (status !== 3'b000) begin bad++; $display("FAIL add_status got=%b want=000", status); end
    issue_cmd(read_cmd(RW'(2)), lat, clean);
    total++; if (longint'(datapath_out) !== m_regs[2]) begin bad++; $display("FAIL add_r2 got=%h want=%h", datapath_out, m_regs[2]); end
  endtask

  task automatic test_overflow();
    int lat; bit clean;
    cmd_t c;
    issue_cmd(imm_cmd(0, HALF - 1), lat, clean);
    issue_cmd(imm_cmd(1, 1), lat, clean);
    c = '{default: '0};
    c.rd = RW'(N - 1); c.rn = RW'(0); c.rm = RW'(1); c.ld_status = 1'b1;
    issue_cmd(c, lat, clean);
    total++; if (longint'(datapath_out) !== HALF) begin bad++; $display("FAIL ovf_out got=%h want=%h", datapath_out, HALF); end
    total++; if (status !== 3'b011) begin bad++; $display("FAIL ovf_status got=%b want=011", status); end
    for (int i = 0; i < N; i++) begin
      issue_cmd(read_cmd(i), lat, clean);
      total++;
      if (longint'(datapath_out) !== m_regs[i]) begin bad++; $display("FAIL ovf_reg%0d got=%h want=%h", i, datapath_out, m_regs[i]); end
    end
  endtask

  task automatic test_sub_and();
    int lat; bit clean;
    cmd_t c;
    c = '{default: '0};
    c.alu_op = 2'b01; c.ld_status = 1'b1;
    issue_cmd(c, lat, clean);
    total++; if (status !== 3'b100) begin bad++; $display("FAIL sub_zero_status got=%b want=100", status); end
    c.alu_op = 2'b10; c.ld_status = 1'b0; c.rn = RW'(0); c.rm = RW'(0);
    issue_cmd(c, lat, clean);
    total++; if (status !== m_status || status !== 3'b100) begin bad++; $display("FAIL and_status_hold got=%b want=100", status); end
    total++; if (longint'(datapath_out) !== m_c) begin bad++; $display("FAIL and_out got=%h want=%h", datapath_out, m_c); end
  endtask

  task automatic test_random();
    int lat; bit clean;
    cmd_t c;
    for (int k = 0; k < 40; k++) begin
      c = rand_cmd();
      issue_cmd(c, lat, clean);
      total++;
      if (lat != ((c.wb_sel == 2'b00) ? 4 : 1) || !clean) begin
        bad++; $display("FAIL rand_lat[%0d] got=%0d clean=%b want=%0d", k, lat, clean, (c.wb_sel == 2'b00) ? 4 : 1);
      end
      total++;
      if (longint'(datapath_out) !== m_c || status !== m_status) begin
        bad++; $display("FAIL rand_res[%0d] got=%h/%b want=%h/%b", k, datapath_out, status, m_c, m_status);
      end
    end
    for (int i = 0; i < N; i++) begin
      issue_cmd(read_cmd(i), lat, clean);
      total++;
      if (longint'(datapath_out) !== m_regs[i]) begin bad++; $display("FAIL rand_reg%0d got=%h want=%h", i, datapath_out, m_regs[i]); end
    end
  endtask

  task automatic test_rd_alias();
    int lat; bit clean;
    cmd_t c;
    issue_cmd(imm_cmd(1, longint'($urandom_range(1, 100))), lat, clean);
    c = '{default: '0};
    c.rd = RW'(1); c.rn = RW'(1); c.rm = RW'(1); c.wr_en = 1'b1; c.ld_status = 1'b1;
    issue_cmd(c, lat, clean);
    issue_cmd(read_cmd(1), lat, clean);
    total++; if (longint'(datapath_out) !== m_regs[1]) begin bad++; $display("FAIL alias_r1 got=%h want=%h", datapath_out, m_regs[1]); end
  endtask

  task automatic test_back_to_back();
    int lat, drops;
    cmd_t c1, c2;
    c1 = rand_cmd(); c1.wb_sel = 2'b00;
    c2 = rand_cmd(); c2.wb_sel = 2'b00;
    drive(c1);
    start = 1'b1;
    @(posedge clk); #1;
    drive(c2);
    lat = 1; drops = 0;
    while (!done && lat < 20) begin
      if (!busy) drops++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
    model_run(c1);
    total++; if (lat != 4 || drops != 0) begin bad++; $display("FAIL b2b_first got=%0d drops=%0d want=4 drops=0", lat, drops); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap got=%b want=0", busy); end
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy); end
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
    model_run(c2);
    @(posedge clk); #1;
    $display("b2b second lat=%0d out=%h st=%b", lat, datapath_out, status);
    total++;
    if (lat != 4 || longint'(datapath_out) !== m_c || status !== m_status) begin
      bad++; $display("FAIL b2b_second got=%0d/%h/%b want=4/%h/%b", lat, datapath_out, status, m_c, m_status);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit clean;
    cmd_t c;
    c = '{default: '0};
    c.alu_op = 2'b11; c.b_imm = 1'b1; c.ld_status = 1'b1;
    issue_cmd(c, lat, clean);
    c = '{default: '0};
    c.rd = RW'(N - 1); c.a_zero = 1'b1; c.b_imm = 1'b1; c.imm = W'(5); c.wr_en = 1'b1;
    drive(c);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    resetn = 1'b0;
    #1;
    model_reset();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || status !== 3'b000 || datapath_out !== '0) begin
      bad++; $display("FAIL midreset_outputs got=%b%b/%b/%h want=00/000/0", busy, done, status, datapath_out);
    end
    @(negedge clk);
    resetn = 1'b1;
    issue_cmd(read_cmd(N - 1), lat, clean);
    total++; if (lat != 4) begin bad++; $display("FAIL midreset_first_start got=%0d want=4", lat); end
    total++; if (longint'(datapath_out) !== m_regs[N-1]) begin bad++; $display("FAIL midreset_unwritten got=%h want=%h", datapath_out, m_regs[N-1]); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_imm_write();
    test_add_shift();
    test_overflow();
    test_sub_and();
    test_rd_alias();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
